// File: rtl/mmu_mem_arbiter_pkg.sv
// Shared encodings for the MMU memory-read arbiter: FSM states, requester ids
// and the round-robin successor helper.
package mmu_mem_arbiter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] REQ_INST = 2'd0;
  localparam logic [1:0] REQ_DATA = 2'd1;
  localparam logic [1:0] REQ_CORE = 2'd2;
  localparam logic [1:0] REQ_NONE = 2'd3;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Next requester in the 0 -> 1 -> 2 -> 0 rotation; REQ_NONE maps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    logic [1:0] nxt;
    case (id)
      REQ_INST: nxt = REQ_DATA;
      REQ_DATA: nxt = REQ_CORE;
      default:  nxt = REQ_INST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mmu_mem_arbiter_pick3.sv
// Combinational 3-way round-robin picker: the search starts just after the
// last served requester and wraps around.
module mmu_rr_pick3
  import mmu_mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] id
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  always_comb begin
    c0    = rr_next(last);
    c1    = rr_next(c0);
    c2    = rr_next(c1);
    valid = |req;
    id    = REQ_NONE;
    if (req[c2]) id = c2;
    if (req[c1]) id = c1;
    if (req[c0]) id = c0;
  end

endmodule

// File: rtl/mmu_mem_arbiter.sv
// Shares one memory read port between the instruction PTW, data PTW and core
// data read, one outstanding transaction at a time, with cancel and timeout.
module mmu_mem_arbiter
  import mmu_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_RDEN,
  input  logic [31:0] REQ0_RADDR,
  output logic        REQ0_RVALID,
  output logic [31:0] REQ0_RDATA,
  input  logic        REQ1_RDEN,
  input  logic [31:0] REQ1_RADDR,
  output logic        REQ1_RVALID,
  output logic [31:0] REQ1_RDATA,
  input  logic        REQ2_RDEN,
  input  logic [31:0] REQ2_RADDR,
  output logic        REQ2_RVALID,
  output logic [31:0] REQ2_RDATA,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_RADDR,
  input  logic [31:0] MEM_ROADDR,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_WAIT,
  output logic [1:0]  GRANT_ID,
  output logic        BUSY,
  output logic        ERR
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nx;
  logic [1:0]  owner;
  logic [1:0]  owner_nx;
  logic [1:0]  last;
  logic [1:0]  last_nx;
  logic [31:0] addr;
  logic [31:0] addr_nx;
  logic [15:0] cnt;

  logic        pick_valid;
  logic [1:0]  pick_id;
  logic [31:0] pick_addr;
  logic        owner_rden;
  logic        active;
  logic        match;
  logic        expire;
  logic        cancel;

  mmu_rr_pick3 u_pick (
    .req   ({REQ2_RDEN, REQ1_RDEN, REQ0_RDEN}),
    .last  (last),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_comb begin
    case (pick_id)
      REQ_INST: pick_addr = REQ0_RADDR;
      REQ_DATA: pick_addr = REQ1_RADDR;
      default:  pick_addr = REQ2_RADDR;
    endcase
    case (owner)
      REQ_INST: owner_rden = REQ0_RDEN;
      REQ_DATA: owner_rden = REQ1_RDEN;
      REQ_CORE: owner_rden = REQ2_RDEN;
      default:  owner_rden = 1'b0;
    endcase
  end

  // A stalled memory or an asserted reset freezes every transaction decision.
  assign active = RST && (state == S_BUSY) && !MEM_WAIT;
  assign match  = active && MEM_RVALID && (MEM_ROADDR == addr);
  assign expire = active && !match && (cnt >= CNT_LAST);
  assign cancel = active && !match && !expire && !owner_rden;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    addr_nx  = addr;
    case (state)
      S_IDLE: begin
        if (pick_valid && !MEM_WAIT) begin
          state_nx = S_BUSY;
          owner_nx = pick_id;
          addr_nx  = pick_addr;
        end
      end
      default: begin
        if (match || expire) begin
          state_nx = S_IDLE;
          owner_nx = REQ_NONE;
          last_nx  = owner;
        end else if (cancel) begin
          state_nx = S_IDLE;
          owner_nx = REQ_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= S_IDLE;
      owner <= REQ_NONE;
      last  <= REQ_CORE;
      addr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      addr  <= addr_nx;
      if (state == S_IDLE) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 16'd1;
    end
  end

  assign REQ0_RVALID = match && (owner == REQ_INST);
  assign REQ1_RVALID = match && (owner == REQ_DATA);
  assign REQ2_RVALID = match && (owner == REQ_CORE);
  assign REQ0_RDATA  = REQ0_RVALID ? MEM_RDATA : '0;
  assign REQ1_RDATA  = REQ1_RVALID ? MEM_RDATA : '0;
  assign REQ2_RDATA  = REQ2_RVALID ? MEM_RDATA : '0;

  assign BUSY      = (state == S_BUSY);
  assign MEM_RDEN  = BUSY;
  assign MEM_RADDR = BUSY ? addr : '0;
  assign GRANT_ID  = owner;
  assign ERR       = expire;

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// Scoreboard bench for mmu_mem_arbiter: directed scenarios plus randomized
// traffic, all checked against a transaction-level reference model.
module tb_mmu_mem_arbiter;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [2:0]  rden;
  logic [31:0] raddr [3];
  logic        rv [3];
  logic [31:0] rd [3];
  logic        mem_rden;
  logic [31:0] mem_raddr;
  logic [31:0] mem_roaddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wait;
  logic [1:0]  grant;
  logic        busy;
  logic        err;

  mmu_mem_arbiter #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_RDEN(rden[0]), .REQ0_RADDR(raddr[0]), .REQ0_RVALID(rv[0]), .REQ0_RDATA(rd[0]),
    .REQ1_RDEN(rden[1]), .REQ1_RADDR(raddr[1]), .REQ1_RVALID(rv[1]), .REQ1_RDATA(rd[1]),
    .REQ2_RDEN(rden[2]), .REQ2_RADDR(raddr[2]), .REQ2_RVALID(rv[2]), .REQ2_RDATA(rd[2]),
    .MEM_RDEN(mem_rden), .MEM_RADDR(mem_raddr), .MEM_ROADDR(mem_roaddr),
    .MEM_RVALID(mem_rvalid), .MEM_RDATA(mem_rdata), .MEM_WAIT(mem_wait),
    .GRANT_ID(grant), .BUSY(busy), .ERR(err)
  );

  typedef struct {
    logic [2:0]  rvs;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        mem_rden;
    logic [31:0] mem_raddr;
    logic [1:0]  grant;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: one outstanding transaction, its owner, address and age.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_age;
  logic [31:0] m_addr;
  bit          e_match;
  bit          e_expire;
  bit          e_cancel;
  logic [2:0]  last_rv;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rvalid", {29'd0, rv[2], rv[1], rv[0]}, {29'd0, e.rvs});
      chk("rdata0", rd[0], e.rd0);
      chk("rdata1", rd[1], e.rd1);
      chk("rdata2", rd[2], e.rd2);
      chk("mem_rd", {mem_rden, mem_raddr[30:0]}, {e.mem_rden, e.mem_raddr[30:0]});
      chk("ctl", {27'd0, mem_raddr[31], grant, busy, err},
          {27'd0, e.mem_raddr[31], e.grant, e.busy, e.err});
    end
  end

  task automatic drive();
    exp_t e;
    bit   act;
    #2;
    act      = RST && m_busy && !mem_wait;
    e_match  = act && mem_rvalid && (mem_roaddr == m_addr);
    e_expire = act && !e_match && (m_age >= TMO);
    e_cancel = act && !e_match && !e_expire && !rden[m_owner];
    e.rvs = 3'b000;
    if (e_match) e.rvs[m_owner] = 1'b1;
    e.rd0       = e.rvs[0] ? mem_rdata : 32'd0;
    e.rd1       = e.rvs[1] ? mem_rdata : 32'd0;
    e.rd2       = e.rvs[2] ? mem_rdata : 32'd0;
    e.mem_rden  = m_busy;
    e.mem_raddr = m_busy ? m_addr : 32'd0;
    e.grant     = m_busy ? 2'(m_owner) : 2'b11;
    e.busy      = m_busy;
    e.err       = e_expire;
    last_rv     = e.rvs;
    sb.push_back(e);
  endtask

  task automatic tick();
    bit found;
    int c;
    if (!RST) begin
      m_busy = 0; m_last = 2; m_owner = 0; m_age = 0; m_addr = 32'd0;
    end else if (!m_busy) begin
      found = 0;
      if (!mem_wait) begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (!found && rden[c]) begin
            found = 1; m_owner = c; m_addr = raddr[c];
          end
        end
      end
      if (found) begin m_busy = 1; m_age = 1; end
    end else begin
      if (e_match || e_expire) begin m_last = m_owner; m_busy = 0; end
      else if (e_cancel) m_busy = 0;
      else if (m_age < 65536) m_age++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    rden = 3'b000; mem_rvalid = 1'b0; mem_wait = 1'b0;
    mem_roaddr = 32'd0; mem_rdata = 32'd0;
  endtask

  task automatic do_reset();
    quiet();
    RST = 1'b0;
    drive();
    tick();
    RST = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin
    RST = 1'b0;
    quiet();
    for (int i = 0; i < 3; i++) raddr[i] = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    m_busy = 0; m_last = 2; m_owner = 0; m_age = 0; m_addr = 32'd0; last_rv = 3'b000;
    RST = 1'b1;
    drive();
    chk("reset_grant", {30'd0, grant}, 32'd3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_memrden", {31'd0, mem_rden}, 32'd0);
    tick();

    // Single read by requester 0.
    do_reset();
    rden[0] = 1'b1; raddr[0] = 32'h0000_1000;
    drive(); tick();
    drive();
    chk("r033_memrden", {31'd0, mem_rden}, 32'd1);
    chk("r033_memraddr", mem_raddr, 32'h0000_1000);
    tick();
    drive(); tick();
    mem_rvalid = 1'b1; mem_roaddr = 32'h0000_1000; mem_rdata = 32'hDEAD_BEEF;
    drive();
    chk("r033_rvalid", {31'd0, rv[0]}, 32'd1);
    chk("r033_rdata", rd[0], 32'hDEAD_BEEF);
    chk("r033_grant", {30'd0, grant}, 32'd0);
    tick();
    quiet(); drive(); tick();

    // All three requesting, memory answers in the first busy cycle.
    do_reset();
    rden = 3'b111;
    raddr[0] = 32'h100; raddr[1] = 32'h200; raddr[2] = 32'h300;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid = 1'b0;
      drive(); tick();
      mem_rvalid = 1'b1; mem_roaddr = raddr[k % 3]; mem_rdata = 32'hA000_0000 + 32'(k);
      drive();
      chk("r034_grant", {30'd0, grant}, 32'(k % 3));
      chk("r034_rvalid", {29'd0, rv[2], rv[1], rv[0]}, 32'(1 << (k % 3)));
      tick();
    end
    quiet(); drive(); tick();

    // Mismatched tag is ignored, correct tag later completes.
    do_reset();
    rden[1] = 1'b1; raddr[1] = 32'h0000_2000;
    drive(); tick();
    mem_rvalid = 1'b1; mem_roaddr = 32'h0000_2004; mem_rdata = 32'h1111_2222;
    drive();
    chk("r035_norv", {29'd0, rv[2], rv[1], rv[0]}, 32'd0);
    chk("r035_busy", {31'd0, busy}, 32'd1);
    tick();
    mem_roaddr = 32'h0000_2000; mem_rdata = 32'h3333_4444;
    drive();
    chk("r035_rv1", {31'd0, rv[1]}, 32'd1);
    chk("r035_rd1", rd[1], 32'h3333_4444);
    tick();
    quiet(); drive(); tick();

    // Timeout abort with no response.
    do_reset();
    rden[2] = 1'b1; raddr[2] = 32'h0000_3000;
    drive(); tick();
    for (int k = 1; k <= 4; k++) begin
      drive();
      chk("r036_err", {31'd0, err}, (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    rden[2] = 1'b0;
    drive();
    chk("r036_idle_busy", {31'd0, busy}, 32'd0);
    chk("r036_idle_grant", {30'd0, grant}, 32'd3);
    tick();

    // Cancel, then cancel coinciding with a matching response.
    do_reset();
    rden[0] = 1'b1; raddr[0] = 32'h0000_4000;
    drive(); tick();
    drive(); tick();
    rden[0] = 1'b0;
    drive();
    chk("r037_cancel_norv", {31'd0, rv[0]}, 32'd0);
    tick();
    drive();
    chk("r037_cancel_idle", {31'd0, busy}, 32'd0);
    tick();
    rden[0] = 1'b1; raddr[0] = 32'h0000_4100;
    drive(); tick();
    rden[0] = 1'b0; mem_rvalid = 1'b1; mem_roaddr = 32'h0000_4100; mem_rdata = 32'h5555_6666;
    drive();
    chk("r037_race_rv", {31'd0, rv[0]}, 32'd1);
    chk("r037_race_rd", rd[0], 32'h5555_6666);
    tick();
    quiet(); drive(); tick();

    // Reset while busy, late response afterwards.
    do_reset();
    rden[1] = 1'b1; raddr[1] = 32'h0000_5000;
    drive(); tick();
    RST = 1'b0;
    drive(); tick();
    RST = 1'b1; rden[1] = 1'b0;
    mem_rvalid = 1'b1; mem_roaddr = 32'h0000_5000; mem_rdata = 32'h7777_8888;
    drive();
    chk("r038_norv", {29'd0, rv[2], rv[1], rv[0]}, 32'd0);
    chk("r038_busy", {31'd0, busy}, 32'd0);
    tick();
    quiet(); drive(); tick();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (last_rv[i]) begin
          if ($urandom_range(1) == 1) begin rden[i] = 1'b1; raddr[i] = rand_addr(); end
          else rden[i] = 1'b0;
        end else if (rden[i]) begin
          if ($urandom_range(99) < 3) rden[i] = 1'b0;
        end else if ($urandom_range(99) < 30) begin
          rden[i] = 1'b1; raddr[i] = rand_addr();
        end
      end
      mem_wait  = ($urandom_range(99) < 10);
      mem_rdata = $urandom;
      if (m_busy && $urandom_range(99) < 40) begin
        mem_rvalid = 1'b1;
        mem_roaddr = ($urandom_range(99) < 70) ? m_addr : (m_addr ^ 32'h4);
      end else begin
        mem_rvalid = ($urandom_range(99) < 5);
        mem_roaddr = rand_addr();
      end
      RST = !($urandom_range(999) < 5);
      drive();
      tick();
    end
    RST = 1'b1;
    quiet();
    drive(); tick();
    @(negedge CLK);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmu_mem_arbiter.md
MMU_MEM_ARBITER -- requirements
Module: mmu_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 256: max cycles in S_BUSY before abort; legal range 2..65535.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous, active-low reset; asserted when 0, sampled on rising CLK.
REQ-004 REQ{0,1,2}_RDEN  input  1  read request per requester, level-held until RVALID or cancel; 0=inst PTW, 1=data PTW, 2=core data read.
REQ-005 REQ{0,1,2}_RADDR  input  32  physical read address; stable while RDEN=1.
REQ-006 REQ{0,1,2}_RVALID  output  1  one-cycle response strobe to that requester.
REQ-007 REQ{0,1,2}_RDATA  output  32  response data; 32'b0 when own RVALID=0.
REQ-008 MEM_RDEN  output  1  shared memory read request.
REQ-009 MEM_RADDR  output  32  shared memory read address; 32'b0 when MEM_RDEN=0.
REQ-010 MEM_ROADDR  input  32  address tag of returning data.
REQ-011 MEM_RVALID  input  1  memory response valid.
REQ-012 MEM_RDATA  input  32  memory response data.
REQ-013 MEM_WAIT  input  1  memory stall; arbiter holds all registered state while 1, except timeout counter.
REQ-014 GRANT_ID  output  2  latched owner; 2'b11 when idle.
REQ-015 BUSY  output  1  1 in S_BUSY.
REQ-016 ERR  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 States: S_IDLE, S_BUSY; encoding 1'b0/1'b1.
REQ-018 S_IDLE: if any REQn_RDEN=1 and MEM_WAIT=0, pick winner round-robin, latch id and REQn_RADDR, go S_BUSY next edge; else stay.
REQ-019 Round-robin: search order starts at (last_served+1) mod 3; last_served resets to 2, so requester 0 wins first after reset.
REQ-020 Grant latency: request seen in cycle N -> MEM_RDEN=1 with latched address in cycle N+1.
REQ-021 S_BUSY: MEM_RDEN=1, MEM_RADDR=latched address, held until exit.
REQ-022 Response match: MEM_RVALID=1 and MEM_ROADDR==latched address -> REQ[owner]_RVALID=1, REQ[owner]_RDATA=MEM_RDATA combinationally same cycle; last_served<=owner; S_IDLE next edge.
REQ-023 MEM_RVALID=1 with mismatched MEM_ROADDR: ignored, no requester strobed, stay S_BUSY.
REQ-024 Cancel: owner's REQn_RDEN=0 in S_BUSY with no matching response that cycle -> S_IDLE next edge, no RVALID, last_served unchanged.
REQ-025 Simultaneous cancel and matching response: response wins, RVALID delivered.
REQ-026 Timeout: 16-bit counter cleared on entry to S_BUSY, increments each S_BUSY cycle (including MEM_WAIT=1); at TIMEOUT-1 without match -> ERR=1 that cycle, S_IDLE next edge, last_served<=owner.
REQ-027 Non-owners never see RVALID=1; at most one REQn_RVALID high per cycle.
REQ-028 Back-to-back: owner re-requests right after its RVALID -> another pending requester wins next arbitration.

Reset
REQ-029 RST=0: state=S_IDLE, last_served=2, latched id=2'b11, latched address=0, counter=0; next cycle all outputs 0 except GRANT_ID=2'b11.
REQ-030 Reset mid-S_BUSY: transaction dropped, no RVALID or ERR, outstanding memory response after reset ignored.

Structure
REQ-031 Shared MMU package/include holds state encodings, requester id constants (REQ_INST=0, REQ_DATA=1, REQ_CORE=2, REQ_NONE=3).
REQ-032 One sub-module, mmu_rr_pick3: combinational 3-way round-robin picker (req[2:0], last[1:0] -> valid, id[1:0]).

Verification
REQ-033 Reset, then REQ0 addr 0x0000_1000; MEM_RVALID cycle 3 with ROADDR 0x0000_1000, RDATA 0xDEAD_BEEF -> MEM_RDEN at cycle 1, REQ0_RVALID=1 with 0xDEAD_BEEF at cycle 3, GRANT_ID=0.
REQ-034 All three requesting continuously, 1-cycle memory -> grant order 0,1,2,0,1,2; no requester starved.
REQ-035 REQ1 granted, RVALID with ROADDR 0x0000_2004 vs latched 0x0000_2000 -> no RVALID; correct tag later -> REQ1_RVALID.
REQ-036 TIMEOUT=4, REQ2 granted, no response -> ERR pulse cycle 4 of S_BUSY, S_IDLE after, GRANT_ID=2'b11.
REQ-037 REQ0 drops RDEN in S_BUSY -> S_IDLE next edge, no REQ0_RVALID; same-cycle cancel + matching RVALID -> RVALID delivered.
REQ-038 RST=0 mid-S_BUSY, late MEM_RVALID after release -> no requester RVALID, BUSY=0.
